note_player: RTL and testbench
==============================

Name: note_player

Overview:
- Sequencer stage directly upstream of the sine reader.
- Takes one note (6-bit note index plus duration in beats) from the song controller and converts the note index to the 20-bit fixed-point phase step the sine reader consumes.
- Gates the codec's 48 kHz sample tick into generate_next_sample for the duration of the note.
- Counts beats down and signals completion so the controller can load the next note.

Parameters:
- DUR_W, 6, width of duration_to_load and the internal beat counter.
- STEP_W, 20, width of step_size: 10 integer bits, 10 fractional bits. Fixed by the sine ROM; not to be overridden.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- play_enable  in  1  1 = run; 0 = pause (beats ignored, sample requests suppressed).
- load_new_note  in  1  single-cycle strobe; latches note_to_load and duration_to_load.
- note_to_load  in  6  0 = rest; 1..63 = equal-tempered piano key number (49 = A4, 440 Hz).
- duration_to_load  in  DUR_W  note length in beats.
- beat  in  1  single-cycle pulse at the beat rate.
- sample_tick  in  1  single-cycle pulse per codec sample (48 kHz).
- generate_next_sample  out  1  request strobe to the sine reader.
- step_size  out  20  {int[9:0], frac[9:0]} phase increment to the sine reader.
- note_done  out  1  single-cycle pulse when a note finishes.
- busy  out  1  high while a note is playing.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, remaining=0; all outputs 0.
- State IDLE:
  - busy=0; generate_next_sample=0; step_size=0.
  - load_new_note=1 with duration_to_load=0: no state change; note_done=1 on the next cycle.
  - load_new_note=1 with duration_to_load>0: go to PLAYING next cycle; remaining=duration_to_load; step_size registered from the note table, valid in the same cycle busy rises.
- State PLAYING:
  - busy=1.
  - generate_next_sample = sample_tick & play_enable, registered, so one cycle of latency from sample_tick.
  - beat & play_enable decrements remaining.
  - A qualified beat while remaining==1 has these effects on the next cycle: note_done=1, busy=0, step_size=0, generate_next_sample=0, state=IDLE.
  - A beat arriving while play_enable=0 is dropped, not deferred.
- Step table:
  - step_raw = round(f × 2^20 / 48000), where f = 440 × 2^((n−49)/12).
  - Implemented as a 64-entry ROM; entry 0 = 0.
  - Anchor values:
    - n=37 (220 Hz) → 4806 = {10'd4, 10'd710}.
    - n=40 (C4) → 5715 = {10'd5, 10'd595}.
    - n=49 → 9612 = {10'd9, 10'd396}.
    - n=61 → 19224 = {10'd18, 10'd792}.
- Rest (note 0): beats are counted and generate_next_sample still pulses, with step_size=0. The sine reader therefore holds a constant output.
- load_new_note while busy=1: ignored. The current note continues unchanged and no note_done is generated for the ignored load.
- load_new_note and beat in the same IDLE cycle: the load is taken; the beat is not counted against the new note.
- note_done and load_new_note in the same cycle (note_done high, state already IDLE): the load is accepted, so back-to-back notes have no gap cycle.
- play_enable deasserted mid-note: remaining and step_size are held. Resuming continues the count from the held value.
- reset asserted mid-note: immediate return to the reset state; no note_done is generated.
- remaining never underflows; the counter is DUR_W bits and only decrements when ≥1.

Test Plan:
- Reset, then load note=49, duration=3, play_enable=1, beats every 20 cycles, sample_tick every 5 cycles → step_size=9612 from the cycle after the load; generate_next_sample follows each tick by 1 cycle; note_done pulses exactly once, 1 cycle after the 3rd beat; step_size then returns to 0.
- Load note=37, duration=2; drop play_enable for 3 beats after the first beat → no ticks forwarded and those 3 beats ignored; after re-enable, note_done follows the 1st subsequent beat; step_size=4806 throughout.
- Load duration=0 (note=40) → note_done one cycle later, busy stays 0, no generate_next_sample.
- Load note=61, duration=1, then assert load note=40 mid-note → second load ignored, step_size stays 19224; on note_done, load note=40 in the same cycle → step_size=5715 the next cycle with no idle gap.
- Load note=0, duration=2 → step_size=0, generate_next_sample still pulses, note_done after the 2nd beat.
- Assert reset while PLAYING with remaining=5 → busy, step_size, generate_next_sample go to 0 asynchronously; no note_done; a fresh load afterwards plays normally.

Source files
------------

// File: rtl/note_player.sv
// note_player: takes one note from the song controller, looks up its phase
// step for the sine reader, gates the codec sample tick into
// generate_next_sample while the note sounds, and counts beats down to a
// single-cycle note_done pulse.
module note_player #(
  parameter int DUR_W  = 6,
  parameter int STEP_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_enable,
  input  logic              load_new_note,
  input  logic [5:0]        note_to_load,
  input  logic [DUR_W-1:0]  duration_to_load,
  input  logic              beat,
  input  logic              sample_tick,
  output logic              generate_next_sample,
  output logic [STEP_W-1:0] step_size,
  output logic              note_done,
  output logic              busy
);

  // Phase step per piano key: round(f * 2^20 / 48000), 10.10 fixed point.
  // Entry 0 is the rest, which keeps the sine reader parked at one phase.
  localparam logic [STEP_W-1:0] STEP_ROM [64] = '{
    20'd0,
    20'd601,   20'd636,   20'd674,   20'd714,   20'd757,   20'd802,
    20'd850,   20'd900,   20'd954,   20'd1010,  20'd1070,  20'd1134,
    20'd1201,  20'd1273,  20'd1349,  20'd1429,  20'd1514,  20'd1604,
    20'd1699,  20'd1800,  20'd1907,  20'd2021,  20'd2141,  20'd2268,
    20'd2403,  20'd2546,  20'd2697,  20'd2858,  20'd3028,  20'd3208,
    20'd3398,  20'd3600,  20'd3815,  20'd4041,  20'd4282,  20'd4536,
    20'd4806,  20'd5092,  20'd5395,  20'd5715,  20'd6055,  20'd6415,
    20'd6797,  20'd7201,  20'd7629,  20'd8083,  20'd8563,  20'd9072,
    20'd9612,  20'd10184, 20'd10789, 20'd11431, 20'd12110, 20'd12830,
    20'd13593, 20'd14402, 20'd15258, 20'd16165, 20'd17127, 20'd18145,
    20'd19224, 20'd20367, 20'd21578
  };

  typedef enum logic {IDLE, PLAYING} state_t;

  state_t           state;
  logic [DUR_W-1:0] remaining;

  // Note sequencing: load in IDLE, count qualified beats in PLAYING, and
  // register every output so the sine reader sees clean strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      remaining            <= '0;
      step_size            <= '0;
      generate_next_sample <= 1'b0;
      note_done            <= 1'b0;
      busy                 <= 1'b0;
    end else begin
      note_done <= 1'b0;
      case (state)
        IDLE: begin
          generate_next_sample <= 1'b0;
          // A beat coinciding with the load is deliberately not counted.
          if (load_new_note) begin
            if (duration_to_load == '0) begin
              note_done <= 1'b1;
            end else begin
              state     <= PLAYING;
              remaining <= duration_to_load;
              step_size <= STEP_ROM[note_to_load];
              busy      <= 1'b1;
            end
          end
        end
        PLAYING: begin
          // Loads are ignored here; the current note runs to completion.
          generate_next_sample <= sample_tick & play_enable;
          if (beat && play_enable && remaining != '0) begin
            if (remaining == DUR_W'(1)) begin
              state                <= IDLE;
              remaining            <= '0;
              step_size            <= '0;
              generate_next_sample <= 1'b0;
              note_done            <= 1'b1;
              busy                 <= 1'b0;
            end else begin
              remaining <= remaining - DUR_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_player.sv
// tb_note_player: directed table vectors, hand-written corner sequences and
// randomized traffic, all checked against a note-level behavioural model
// whose phase steps come from the equal-tempered frequency formula.
module tb_note_player;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        play_enable = 1'b0;
  logic        load_new_note = 1'b0;
  logic [5:0]  note_to_load = '0;
  logic [5:0]  duration_to_load = '0;
  logic        beat = 1'b0;
  logic        sample_tick = 1'b0;
  logic        generate_next_sample;
  logic [19:0] step_size;
  logic        note_done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Model state: is a note sounding, beats still owed, and expected outputs.
  int m_busy, m_left, m_step, m_gen, m_done;

  note_player #(.DUR_W(6), .STEP_W(20)) dut (
    .clk                  (clk),
    .reset                (reset),
    .play_enable          (play_enable),
    .load_new_note        (load_new_note),
    .note_to_load         (note_to_load),
    .duration_to_load     (duration_to_load),
    .beat                 (beat),
    .sample_tick          (sample_tick),
    .generate_next_sample (generate_next_sample),
    .step_size            (step_size),
    .note_done            (note_done),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  // Phase step from the musical definition of the key.
  function automatic int ref_step(int n);
    real f;
    if (n == 0) return 0;
    f = 440.0 * (2.0 ** ((n - 49) / 12.0));
    return $rtoi($floor(f * 1048576.0 / 48000.0 + 0.5));
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    m_busy = 0; m_left = 0; m_step = 0; m_gen = 0; m_done = 0;
  endtask

  // Advance the note model by one clock using the inputs seen at the edge.
  task automatic model_edge();
    if (!reset) begin
      model_clear();
    end else if (m_busy == 0) begin
      m_done = 0;
      m_gen  = 0;
      if (load_new_note) begin
        if (duration_to_load == 0) m_done = 1;
        else begin
          m_busy = 1;
          m_left = int'(duration_to_load);
          m_step = ref_step(int'(note_to_load));
        end
      end
    end else begin
      m_done = 0;
      m_gen  = (sample_tick && play_enable) ? 1 : 0;
      if (beat && play_enable) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_busy = 0; m_step = 0; m_gen = 0; m_done = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("busy", int'(busy), m_busy);
    check("step_size", int'(step_size), m_step);
    check("generate_next_sample", int'(generate_next_sample), m_gen);
    check("note_done", int'(note_done), m_done);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_edge();
    compare_all();
  endtask

  // One clock with the given strobes; strobes drop again afterwards.
  task automatic drive(input bit ld, input int n, input int d, input bit bt, input bit tk);
    load_new_note    = ld;
    note_to_load     = 6'(n);
    duration_to_load = 6'(d);
    beat             = bt;
    sample_tick      = tk;
    cycle();
    load_new_note = 1'b0;
    beat          = 1'b0;
    sample_tick   = 1'b0;
  endtask

  typedef struct {
    int note;
    int dur;
    int exp_step;
  } vec_t;

  vec_t vecs[6];
  int   done_cnt;

  initial begin
    vecs[0] = '{37, 1, 4806};
    vecs[1] = '{40, 2, 5715};
    vecs[2] = '{49, 1, 9612};
    vecs[3] = '{61, 3, 19224};
    vecs[4] = '{0,  1, 0};
    vecs[5] = '{1,  1, 601};
    model_clear();

    // Reset state.
    cycle();
    cycle();
    reset = 1'b1;
    play_enable = 1'b1;
    cycle();

    // Anchor steps: load, check the step, then beat the note out.
    foreach (vecs[i]) begin
      drive(1, vecs[i].note, vecs[i].dur, 0, 0);
      check("tbl_step", int'(step_size), vecs[i].exp_step);
      for (int b = 0; b < vecs[i].dur; b++) drive(0, 0, 0, 1, 1);
      check("tbl_done", int'(note_done), 1);
      check("tbl_step_zero", int'(step_size), 0);
    end

    // Whole key range against the frequency formula.
    for (int n = 0; n < 64; n++) begin
      drive(1, n, 1, 0, 0);
      drive(0, 0, 0, 1, 0);
    end

    // A4 for 3 beats, beat every 20 clocks, tick every 5.
    done_cnt = 0;
    for (int c = 0; c < 70; c++) begin
      drive(c == 0, 49, 3, (c % 20) == 19, (c % 5) == 2);
      if (c == 0) check("a4_step", int'(step_size), 9612);
      if (note_done) done_cnt++;
    end
    check("a4_done_count", done_cnt, 1);

    // A3 for 2 beats with a pause swallowing three beats and ticks.
    drive(1, 37, 2, 0, 0);
    drive(0, 0, 0, 1, 0);
    play_enable = 1'b0;
    for (int b = 0; b < 3; b++) begin
      drive(0, 0, 0, 1, 1);
      check("pause_no_gen", int'(generate_next_sample), 0);
      check("pause_busy", int'(busy), 1);
    end
    play_enable = 1'b1;
    drive(0, 0, 0, 0, 1);
    check("resume_step", int'(step_size), 4806);
    drive(0, 0, 0, 1, 0);
    check("resume_done", int'(note_done), 1);

    // Zero duration: done next cycle, never busy.
    drive(1, 40, 0, 0, 1);
    check("zero_done", int'(note_done), 1);
    check("zero_busy", int'(busy), 0);

    // Load while busy ignored; back-to-back load on note_done.
    drive(1, 61, 1, 0, 0);
    drive(1, 40, 1, 0, 0);
    check("ignored_load_step", int'(step_size), 19224);
    drive(0, 0, 0, 1, 0);
    check("b2b_done", int'(note_done), 1);
    drive(1, 40, 1, 0, 0);
    check("b2b_step", int'(step_size), 5715);
    check("b2b_busy", int'(busy), 1);
    drive(0, 0, 0, 1, 0);

    // Rest: ticks still forwarded, step stays 0.
    drive(1, 0, 2, 0, 0);
    drive(0, 0, 0, 0, 1);
    check("rest_gen", int'(generate_next_sample), 1);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    check("rest_done", int'(note_done), 1);

    // Asynchronous reset with 5 beats still owed.
    drive(1, 49, 7, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 1);
    #2 reset = 1'b0;
    #1;
    model_clear();
    check("async_busy", int'(busy), 0);
    check("async_step", int'(step_size), 0);
    check("async_gen", int'(generate_next_sample), 0);
    drive(0, 0, 0, 1, 1);
    check("async_no_done", int'(note_done), 0);
    reset = 1'b1;
    drive(1, 13, 1, 0, 0);
    check("after_reset_step", int'(step_size), 1201);
    drive(0, 0, 0, 1, 0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      play_enable = ($urandom_range(0, 9) < 8);
      reset = ($urandom_range(0, 499) != 0);
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 63), $urandom_range(0, 6),
            $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
